gray_sequencer: RTL and testbench
=================================

# gray_sequencer

- Streaming Gray-code source.
- Holds a binary index counter and presents the index with its standard reflected Gray encoding (gray = idx ^ (idx >> 1)) on a valid/ready output.
- Steps the index up or down by one per accepted transfer.
- Feeds Gray-coded values into pointer-crossing and encoder-test paths; the binary index travels alongside so a downstream Gray-to-binary stage can be checked beat by beat.

## Interface
- DATA_WIDTH, default 16: width of index and Gray word; legal range 2..32.

- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- load  in  1  load request, sampled every cycle
- load_idx  in  DATA_WIDTH  start index for load
- en  in  1  run enable
- dir  in  1  step direction: 1 = up, 0 = down
- out_ready  in  1  downstream ready
- out_valid  out  1  output word valid
- gray  out  DATA_WIDTH  Gray encoding of idx
- idx  out  DATA_WIDTH  current binary index
- wrap  out  1  presented word resulted from wrap-around

## Operation
- States: IDLE (out_valid=0) and ACTIVE (out_valid=1).
- All outputs are registered.
- gray equals idx ^ (idx >> 1) on every cycle, including during reset.
- Priority per cycle: reset > load > handshake/en.
- Load, any state:
  - next cycle: idx=load_idx, gray=enc(load_idx), wrap=0, state ACTIVE.
  - A transfer in the same cycle as a load is discarded; the loaded value replaces it.
- IDLE, en=1, no load: next cycle state ACTIVE, presenting the current idx unchanged.
- IDLE, en=0: hold all outputs.
- ACTIVE, out_ready=0: idx, gray, wrap and out_valid hold stable.
- ACTIVE, out_valid && out_ready, en=1:
  - idx steps ±1 modulo 2^DATA_WIDTH according to dir.
  - Stays ACTIVE, so one word per cycle is sustained.
- ACTIVE, out_valid && out_ready, en=0: next state IDLE, out_valid=0, idx unchanged. The last word was consumed and is not re-issued.
- wrap:
  - Set with a step that crosses all-ones→0 (up) or 0→all-ones (down).
  - Cleared by the next non-wrapping step or by a load.
  - Holds during a stall.
- dir is sampled only at the accepting edge. Changing dir during a stall has no effect until acceptance.
- Consecutive accepted Gray words, with no load between them, differ in exactly one bit, including across a wrap.

## Timing
- Reset (resetn low): idx=0, gray=0, out_valid=0, wrap=0, state IDLE. Takes effect immediately, without waiting for a clock edge.
- Reset deassertion is synchronized by the system. The first active edge is the cycle after resetn rises.
- Latency: load → out_valid 1 cycle; IDLE+en → out_valid 1 cycle; accept → next word 1 cycle.
- Reset mid-stream: the pending word is dropped, and the block returns to IDLE with idx=0.
- out_valid does not depend combinationally on out_ready.

## Configuration
- GRAY_SEQ_DOWN_EN defined: dir input honoured; down-counting and down-wrap (0→all-ones, wrap=1) supported.
- GRAY_SEQ_DOWN_EN undefined:
  - dir ignored and treated as 1; only up-counting logic is built.
  - The port remains present so instantiations are unchanged.

## Test plan
- Reset, DATA_WIDTH=4: hold resetn=0 for 3 cycles → idx=0, gray=0000, out_valid=0, wrap=0; release with en=1 → next cycle out_valid=1, gray=0000.
- Load and stream, DATA_WIDTH=4: load_idx=5, en=1, dir=1, out_ready=1 → gray 0111, 0101, 0100, 1100 with idx 5, 6, 7, 8 on consecutive cycles. Each step changes exactly one bit.
- Up-wrap: load_idx=15 (gray 1000), accept → idx=0, gray=0000, wrap=1; next accept → idx=1, gray=0001, wrap=0.
- Backpressure and stop:
  - ACTIVE at idx=9, out_ready=0 for 3 cycles → idx=9, gray=1101 held stable, out_valid=1.
  - Then out_ready=1 with en=0 → out_valid=0 next cycle, idx stays 9.
- Direction, DATA_WIDTH=4, load_idx=0, dir=0, one accept:
  - With GRAY_SEQ_DOWN_EN → idx=15, gray=1000, wrap=1.
  - Without GRAY_SEQ_DOWN_EN → idx=1, gray=0001, wrap=0.
- Load/reset collisions:
  - Load 3 in the same cycle as an accept at idx=7 → next idx=3, gray=0010.
  - resetn low mid-stream between clock edges → outputs go to zero immediately.

Source files
------------

// File: rtl/gray_sequencer.sv
// gray_sequencer
//   Streaming Gray-code source. A binary index counter is presented together
//   with its reflected Gray encoding (gray = idx ^ (idx >> 1)) on a
//   valid/ready output. The index steps by one per accepted transfer.
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
//   out_valid is a pure register output and never looks at out_ready. While
//   out_valid=1 and out_ready=0, idx/gray/wrap/out_valid hold stable.
//
// Configuration macro: GRAY_SEQ_DOWN_EN
//   defined   : dir selects up (1) or down (0) stepping, with down-wrap.
//   undefined : dir is ignored (treated as 1). Only the incrementer is built.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   load       in   load request (highest priority after reset)
//   load_idx   in   [DATA_WIDTH] start index for a load
//   en         in   run enable
//   dir        in   step direction, 1 = up, 0 = down
//   out_ready  in   downstream ready
//   out_valid  out  output word valid (state ACTIVE)
//   gray       out  [DATA_WIDTH] Gray encoding of idx
//   idx        out  [DATA_WIDTH] current binary index
//   wrap       out  presented word came from a wrap-around step
//   dbg_state  out  FSM state, 0 = IDLE, 1 = ACTIVE
module gray_sequencer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_idx,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] gray,
  output logic [DATA_WIDTH-1:0] idx,
  output logic                  wrap,
  output logic                  dbg_state
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_gray;
  logic                  r_wrap;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_idx_nxt;
  logic                  w_wrap_nxt;
  logic [DATA_WIDTH-1:0] w_idx_step;
  logic                  w_step_wrap;

  // Value and wrap flag of a single step away from the current index.
`ifdef GRAY_SEQ_DOWN_EN
  assign w_idx_step  = dir ? (r_idx + ONE) : (r_idx - ONE);
  assign w_step_wrap = dir ? (r_idx == ALL_ONES) : (r_idx == '0);
`else
  logic w_unused_dir;
  assign w_unused_dir = dir;
  assign w_idx_step   = r_idx + ONE;
  assign w_step_wrap  = (r_idx == ALL_ONES);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wrap_nxt  = r_wrap;
    if (load) begin
      // A transfer coinciding with a load is discarded.
      w_state_nxt = S_ACTIVE;
      w_idx_nxt   = load_idx;
      w_wrap_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (en) w_state_nxt = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (out_ready) begin
            if (en) begin
              w_idx_nxt  = w_idx_step;
              w_wrap_nxt = w_step_wrap;
            end else begin
              // Last word consumed; go quiet without re-issuing it.
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // gray is registered from the next index so it is always enc(idx).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_gray  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_gray  <= w_idx_nxt ^ (w_idx_nxt >> 1);
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign out_valid = (r_state == S_ACTIVE);
  assign idx       = r_idx;
  assign gray      = r_gray;
  assign wrap      = r_wrap;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_gray_sequencer.sv
module tb_gray_sequencer;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_idx = '0;
  logic         en = 1'b0;
  logic         dir = 1'b1;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] gray;
  logic [W-1:0] idx;
  logic         wrap;
  logic         dbg_state;

  always #5 clk = ~clk;

  gray_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .load(load), .load_idx(load_idx),
    .en(en), .dir(dir), .out_ready(out_ready), .out_valid(out_valid),
    .gray(gray), .idx(idx), .wrap(wrap), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int enc(input int v);
    return (v ^ (v >> 1)) % MOD;
  endfunction

  function automatic int popcount(input int v);
    int c = 0;
    for (int b = 0; b < W; b++) c += (v >> b) & 1;
    return c;
  endfunction

  // ---------------- behavioural model ----------------
  int m_idx = 0;
  bit m_valid = 0;
  bit m_wrap = 0;
  bit have_prev = 0;
  int prev_gray = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_idx = 0; m_valid = 0; m_wrap = 0; have_prev = 0;
    end else if (load) begin
      m_idx = load_idx; m_valid = 1; m_wrap = 0; have_prev = 0;
    end else if (!m_valid) begin
      if (en) m_valid = 1;
    end else if (out_ready) begin
      // A word is accepted here; DUT outputs still show the pre-edge word.
      if (have_prev && popcount(prev_gray ^ gray) != 1) begin
        checks++;
        errors++;
        $display("FAIL one_bit_step prev=%0d cur=%0d", prev_gray, gray);
      end else if (have_prev) begin
        checks++;
      end
      if (en) begin
        bit up;
`ifdef GRAY_SEQ_DOWN_EN
        up = dir;
`else
        up = 1;
`endif
        prev_gray = gray;
        have_prev = 1;
        m_wrap = up ? (m_idx == MOD - 1) : (m_idx == 0);
        m_idx  = up ? (m_idx + 1) % MOD : (m_idx + MOD - 1) % MOD;
      end else begin
        m_valid = 0;
        have_prev = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("out_valid", out_valid, m_valid);
    check("idx", idx, m_idx);
    check("gray", gray, enc(m_idx));
    check("wrap", wrap, m_wrap);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for 3 cycles.
    repeat (3) tick();
    check("rst_idx", idx, 0);
    check("rst_gray", gray, 0);
    check("rst_valid", out_valid, 0);
    check("rst_wrap", wrap, 0);

    // Release with en=1: one cycle later word 0 is presented.
    resetn = 1; en = 1; out_ready = 0;
    tick();
    check("rel_valid", out_valid, 1);
    check("rel_gray", gray, 0);

    // Load 5 and stream.
    load = 1; load_idx = 5; dir = 1; out_ready = 1;
    exp_q.push_back(4'b0111); exp_q.push_back(4'b0101);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1100);
    tick();
    load = 0;
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("stream_gray", gray, e);
      check("stream_idx", idx, 5 + k);
      if (k < 3) tick();
    end

    // Up-wrap.
    load = 1; load_idx = 15;
    tick();
    load = 0;
    check("wrap_load_gray", gray, 4'b1000);
    tick();
    check("wrap_idx", idx, 0);
    check("wrap_gray", gray, 0);
    check("wrap_flag", wrap, 1);
    tick();
    check("wrap_next_gray", gray, 4'b0001);
    check("wrap_clear", wrap, 0);

    // Backpressure, dir toggled during stall must have no effect.
    load = 1; load_idx = 9;
    tick();
    load = 0; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      dir = ~dir;
      tick();
      check("stall_idx", idx, 9);
      check("stall_gray", gray, 4'b1101);
      check("stall_valid", out_valid, 1);
    end
    dir = 1; en = 0; out_ready = 1;
    tick();
    check("stop_valid", out_valid, 0);
    check("stop_idx", idx, 9);

    // Direction from 0.
    en = 1; load = 1; load_idx = 0; dir = 0;
    tick();
    load = 0;
    tick();
`ifdef GRAY_SEQ_DOWN_EN
    check("down_idx", idx, 15);
    check("down_gray", gray, 4'b1000);
    check("down_wrap", wrap, 1);
`else
    check("updir_idx", idx, 1);
    check("updir_gray", gray, 4'b0001);
    check("updir_wrap", wrap, 0);
`endif
    dir = 1;

    // Load collides with an accept at idx 7.
    load = 1; load_idx = 7;
    tick();
    load_idx = 3;
    tick();
    load = 0;
    check("coll_idx", idx, 3);
    check("coll_gray", gray, 4'b0010);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 resetn = 0;
    #1;
    check("async_idx", idx, 0);
    check("async_gray", gray, 0);
    check("async_valid", out_valid, 0);
    tick();
    tick();
    resetn = 1;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      load      = ($urandom_range(0, 9) == 0);
      load_idx  = W'($urandom_range(0, MOD - 1));
      en        = ($urandom_range(0, 3) != 0);
      dir       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
